// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the decode stage.
//   imm_src_t      - immediate format selector
//   REGSRC_RA1_PC  - bit of regsrc that forces RA1 to the PC register
//   REGSRC_RA2_RD  - bit of regsrc that takes RA2 from inst[15:12]
//   PC_INC_DEF     - default offset added to PC+4 for PC-register reads
package decode_pkg;

    typedef enum logic [1:0] {
        IMM_8   = 2'b00,
        IMM_12  = 2'b01,
        IMM_BR  = 2'b10,
        IMM_RSV = 2'b11
    } imm_src_t;

    localparam int REGSRC_RA1_PC = 0;
    localparam int REGSRC_RA2_RD = 1;
    localparam int PC_INC_DEF    = 4;

endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: NREGS x DW register file, two async read ports, one write
// port. Reads see a same-cycle write (write-through bypass); the PC_REG index
// always reads pc_val_i and is never written.
//   clk, reset      - clock, async active-low clear of all entries
//   ra1_i, ra2_i    - read addresses
//   pc_val_i        - value returned for PC_REG reads
//   we_i, wa_i, wd_i- write enable / address / data
//   rd1_o, rd2_o    - read data
module decode_regfile #(
    parameter int DW     = 32,
    parameter int NREGS  = 16,
    parameter int PC_REG = NREGS - 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra1_i,
    input  logic [AW-1:0] ra2_i,
    input  logic [DW-1:0] pc_val_i,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [DW-1:0] wd_i,
    output logic [DW-1:0] rd1_o,
    output logic [DW-1:0] rd2_o
);
    import decode_pkg::*;

    localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG);

    logic [NREGS-1:0][DW-1:0] mem_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '0;
        end else if (we_i && (wa_i != PC_ADDR)) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // PC override beats the bypass, so a dropped PC write never leaks through.
    function automatic logic [DW-1:0] rd_sel(input logic [AW-1:0] ra);
        if (ra == PC_ADDR)              return pc_val_i;
        else if (we_i && (wa_i == ra))  return wd_i;
        else                            return mem_q[ra];
    endfunction

    always_comb begin
        rd1_o = rd_sel(ra1_i);
        rd2_o = rd_sel(ra2_i);
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: register read with write-through bypass, PC-relative read
// of PC_REG, immediate extension and SrcB selection, all captured in an ID/EX
// register with valid / stall / flush control (flush wins over stall).
//   clk, reset          - clock, async active-low reset
//   valid_d .. regwrite_d - decode-stage instruction and controls
//   stall_e, flush_e    - ID/EX hold / bubble
//   regwrite_w, wa3_w, result_w - writeback port (independent of stall/flush)
//   *_e outputs         - registered operands, addresses and controls
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int DW     = 32,
    parameter int NREGS  = 16,
    parameter int AW     = $clog2(NREGS),
    parameter int PC_REG = NREGS - 1,
    parameter int PC_INC = PC_INC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_d,
    input  logic [31:0]   inst_d,
    input  logic [DW-1:0] pcplus4_d,
    input  logic [1:0]    regsrc_d,
    input  logic [1:0]    immsrc_d,
    input  logic          alusrc_d,
    input  logic          regwrite_d,
    input  logic          stall_e,
    input  logic          flush_e,
    input  logic          regwrite_w,
    input  logic [AW-1:0] wa3_w,
    input  logic [DW-1:0] result_w,
    output logic          valid_e,
    output logic          regwrite_e,
    output logic [DW-1:0] rd1_e,
    output logic [DW-1:0] rd2_e,
    output logic [DW-1:0] extimm_e,
    output logic [DW-1:0] srcb_e,
    output logic [DW-1:0] pcplus8_e,
    output logic [AW-1:0] ra1_e,
    output logic [AW-1:0] ra2_e,
    output logic [AW-1:0] wa3_e
);

    localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG);

    logic [AW-1:0] ra1_d, ra2_d, wa3_d;
    logic [DW-1:0] pcplus8_d, rd1_d, rd2_d, extimm_d, srcb_d;
    logic          unused_inst;

    assign unused_inst = ^inst_d[31:24];

    assign ra1_d     = regsrc_d[REGSRC_RA1_PC] ? PC_ADDR : AW'(inst_d[19:16]);
    assign ra2_d     = regsrc_d[REGSRC_RA2_RD] ? AW'(inst_d[15:12]) : AW'(inst_d[3:0]);
    assign wa3_d     = AW'(inst_d[15:12]);
    assign pcplus8_d = pcplus4_d + DW'(PC_INC);   // wraps silently

    decode_regfile #(.DW(DW), .NREGS(NREGS), .PC_REG(PC_REG), .AW(AW)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .ra1_i    (ra1_d),
        .ra2_i    (ra2_d),
        .pc_val_i (pcplus8_d),
        .we_i     (regwrite_w),
        .wa_i     (wa3_w),
        .wd_i     (result_w),
        .rd1_o    (rd1_d),
        .rd2_o    (rd2_d)
    );

    always_comb begin
        extimm_d = '0;
        case (imm_src_t'(immsrc_d))
            IMM_8:   extimm_d = DW'(inst_d[7:0]);
            IMM_12:  extimm_d = DW'(inst_d[11:0]);
            IMM_BR:  extimm_d = DW'($signed({inst_d[23:0], 2'b00}));
            default: extimm_d = '0;
        endcase
    end

    assign srcb_d = alusrc_d ? extimm_d : rd2_d;

    // ID/EX register
    logic          valid_q, regwrite_q;
    logic [DW-1:0] rd1_q, rd2_q, extimm_q, srcb_q, pcplus8_q;
    logic [AW-1:0] ra1_q, ra2_q, wa3_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            extimm_q   <= '0;
            srcb_q     <= '0;
            pcplus8_q  <= '0;
            ra1_q      <= '0;
            ra2_q      <= '0;
            wa3_q      <= '0;
        end else if (flush_e) begin
            // Bubble: only the control bits clear, data is left stale.
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (!stall_e) begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d & valid_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            extimm_q   <= extimm_d;
            srcb_q     <= srcb_d;
            pcplus8_q  <= pcplus8_d;
            ra1_q      <= ra1_d;
            ra2_q      <= ra2_d;
            wa3_q      <= wa3_d;
        end
    end

    assign valid_e    = valid_q;
    assign regwrite_e = regwrite_q;
    assign rd1_e      = rd1_q;
    assign rd2_e      = rd2_q;
    assign extimm_e   = extimm_q;
    assign srcb_e     = srcb_q;
    assign pcplus8_e  = pcplus8_q;
    assign ra1_e      = ra1_q;
    assign ra2_e      = ra2_q;
    assign wa3_e      = wa3_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: a default 32-bit/16-reg instance and a
// 64-bit/32-reg instance, both on the same clock and reset.
module tb_decode_stage_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 32-bit instance
    logic        valid_d, alusrc_d, regwrite_d, stall_e, flush_e, regwrite_w;
    logic [31:0] inst_d, pcplus4_d, result_w;
    logic [1:0]  regsrc_d, immsrc_d;
    logic [3:0]  wa3_w;
    logic        valid_e, regwrite_e;
    logic [31:0] rd1_e, rd2_e, extimm_e, srcb_e, pcplus8_e;
    logic [3:0]  ra1_e, ra2_e, wa3_e;

    decode_stage_pipe dut (
        .clk(clk), .reset(reset), .valid_d(valid_d), .inst_d(inst_d),
        .pcplus4_d(pcplus4_d), .regsrc_d(regsrc_d), .immsrc_d(immsrc_d),
        .alusrc_d(alusrc_d), .regwrite_d(regwrite_d), .stall_e(stall_e),
        .flush_e(flush_e), .regwrite_w(regwrite_w), .wa3_w(wa3_w),
        .result_w(result_w), .valid_e(valid_e), .regwrite_e(regwrite_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .extimm_e(extimm_e), .srcb_e(srcb_e),
        .pcplus8_e(pcplus8_e), .ra1_e(ra1_e), .ra2_e(ra2_e), .wa3_e(wa3_e)
    );

    // 64-bit instance
    logic        w_valid_d, w_alusrc_d, w_regwrite_d, w_regwrite_w;
    logic [31:0] w_inst_d;
    logic [63:0] w_pcplus4_d, w_result_w;
    logic [1:0]  w_regsrc_d, w_immsrc_d;
    logic [4:0]  w_wa3_w;
    logic        w_valid_e, w_regwrite_e;
    logic [63:0] w_rd1_e, w_rd2_e, w_extimm_e, w_srcb_e, w_pcplus8_e;
    logic [4:0]  w_ra1_e, w_ra2_e, w_wa3_e;

    decode_stage_pipe #(.DW(64), .NREGS(32)) dut64 (
        .clk(clk), .reset(reset), .valid_d(w_valid_d), .inst_d(w_inst_d),
        .pcplus4_d(w_pcplus4_d), .regsrc_d(w_regsrc_d), .immsrc_d(w_immsrc_d),
        .alusrc_d(w_alusrc_d), .regwrite_d(w_regwrite_d), .stall_e(1'b0),
        .flush_e(1'b0), .regwrite_w(w_regwrite_w), .wa3_w(w_wa3_w),
        .result_w(w_result_w), .valid_e(w_valid_e), .regwrite_e(w_regwrite_e),
        .rd1_e(w_rd1_e), .rd2_e(w_rd2_e), .extimm_e(w_extimm_e), .srcb_e(w_srcb_e),
        .pcplus8_e(w_pcplus8_e), .ra1_e(w_ra1_e), .ra2_e(w_ra2_e), .wa3_e(w_wa3_e)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        valid_d = 0; inst_d = 32'h0001_0002; pcplus4_d = 0; regsrc_d = 0; immsrc_d = 0;
        alusrc_d = 0; regwrite_d = 0; stall_e = 0; flush_e = 0;
        regwrite_w = 0; wa3_w = 0; result_w = 0;
        w_valid_d = 0; w_inst_d = 0; w_pcplus4_d = 0; w_regsrc_d = 0; w_immsrc_d = 0;
        w_alusrc_d = 0; w_regwrite_d = 0; w_regwrite_w = 0; w_wa3_w = 0; w_result_w = 0;

        // Reset: outputs zero while low and one cycle after release
        #12;
        chk("rst_valid", 64'(valid_e), 64'd0);
        chk("rst_rd1", 64'(rd1_e), 64'd0);
        chk("rst_rd2", 64'(rd2_e), 64'd0);
        reset = 1'b1;
        tick;
        chk("post_rst_valid", 64'(valid_e), 64'd0);
        chk("post_rst_rd1", 64'(rd1_e), 64'd0);
        chk("post_rst_rd2", 64'(rd2_e), 64'd0);

        // Same-cycle write-through bypass of R3 into RA1
        valid_d = 1; regwrite_d = 1; inst_d = 32'h0003_0000;
        regwrite_w = 1; wa3_w = 4'd3; result_w = 32'hDEADBEEF;
        tick;
        chk("bypass_rd1", 64'(rd1_e), 64'hDEADBEEF);
        chk("bypass_valid", 64'(valid_e), 64'd1);
        chk("bypass_regwrite", 64'(regwrite_e), 64'd1);
        chk("bypass_ra1", 64'(ra1_e), 64'd3);
        regwrite_w = 0;

        // Stored R3 via RA2 = inst[3:0], imm8 = 0x03
        inst_d = 32'h0000_0003;
        tick;
        chk("stored_rd2", 64'(rd2_e), 64'hDEADBEEF);
        chk("stored_srcb", 64'(srcb_e), 64'hDEADBEEF);
        chk("imm8", 64'(extimm_e), 64'h3);

        // PC read via regsrc[0]
        regsrc_d = 2'b01; pcplus4_d = 32'h100; inst_d = 32'h0;
        tick;
        chk("pc_rd1", 64'(rd1_e), 64'h104);
        chk("pc_pcplus8", 64'(pcplus8_e), 64'h104);
        chk("pc_ra1", 64'(ra1_e), 64'd15);
        // Write to R15 in the same cycle: override wins, write dropped
        regwrite_w = 1; wa3_w = 4'd15; result_w = 32'h55;
        tick;
        chk("pc_override_bypass", 64'(rd1_e), 64'h104);
        regwrite_w = 0;
        regsrc_d = 2'b00; inst_d = 32'h0000_000F;
        tick;
        chk("pc_rd2_after_write", 64'(rd2_e), 64'h104);

        // Immediates and SrcB
        immsrc_d = 2'b10; inst_d = 32'h00FF_FFFE; alusrc_d = 1;
        tick;
        chk("imm_br", 64'(extimm_e), 64'hFFFF_FFF8);
        chk("imm_br_srcb", 64'(srcb_e), 64'hFFFF_FFF8);
        immsrc_d = 2'b01; inst_d = 32'h0000_0ABC;
        tick;
        chk("imm12_srcb", 64'(srcb_e), 64'h0000_0ABC);
        immsrc_d = 2'b00;
        tick;
        chk("imm8_trunc", 64'(extimm_e), 64'hBC);
        immsrc_d = 2'b11;
        tick;
        chk("imm_rsv", 64'(extimm_e), 64'h0);

        // Load a known instruction, then stall 3 cycles with changing D
        immsrc_d = 0; alusrc_d = 0; inst_d = 32'h0003_0000; pcplus4_d = 32'h200;
        tick;
        chk("pre_stall_rd1", 64'(rd1_e), 64'hDEADBEEF);
        chk("pre_stall_pc8", 64'(pcplus8_e), 64'h204);
        stall_e = 1; regwrite_w = 1; wa3_w = 4'd5; result_w = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            inst_d = 32'h0001_0002 + i; pcplus4_d = 32'h300 + i;
            valid_d = i[0]; regwrite_d = 0; regsrc_d = 2'b01;
            tick;
            chk("stall_rd1", 64'(rd1_e), 64'hDEADBEEF);
            chk("stall_pc8", 64'(pcplus8_e), 64'h204);
            chk("stall_valid", 64'(valid_e), 64'd1);
            chk("stall_regwrite", 64'(regwrite_e), 64'd1);
            chk("stall_ra1", 64'(ra1_e), 64'd3);
        end
        regwrite_w = 0;
        // Flush beats stall
        flush_e = 1;
        tick;
        chk("flush_valid", 64'(valid_e), 64'd0);
        chk("flush_regwrite", 64'(regwrite_e), 64'd0);
        chk("flush_rd1_hold", 64'(rd1_e), 64'hDEADBEEF);
        chk("flush_pc8_hold", 64'(pcplus8_e), 64'h204);
        // Writeback during stall landed in R5
        flush_e = 0; stall_e = 0; regsrc_d = 0; valid_d = 1; regwrite_d = 0;
        inst_d = 32'h0005_0000; pcplus4_d = 32'h300;
        tick;
        chk("wb_in_stall_rd1", 64'(rd1_e), 64'h1234);
        chk("resume_valid", 64'(valid_e), 64'd1);
        chk("resume_pc8", 64'(pcplus8_e), 64'h304);
        // regwrite gated by valid
        valid_d = 0; regwrite_d = 1;
        tick;
        chk("gate_regwrite", 64'(regwrite_e), 64'd0);

        // 64-bit instance: PC wrap, PC_REG=31 override, 64-bit storage
        w_valid_d = 1; w_regsrc_d = 2'b01; w_pcplus4_d = 64'hFFFF_FFFF_FFFF_FFFC;
        tick;
        chk("w_pc8_wrap", w_pcplus8_e, 64'h0);
        chk("w_rd1_wrap", w_rd1_e, 64'h0);
        chk("w_ra1", 64'(w_ra1_e), 64'd31);
        w_pcplus4_d = 64'h1000; w_regwrite_w = 1; w_wa3_w = 5'd31; w_result_w = 64'h77;
        tick;
        chk("w_r31_override", w_rd1_e, 64'h1004);
        w_wa3_w = 5'd1; w_result_w = 64'h1122_3344_5566_7788;
        tick;
        chk("w_r31_after", w_rd1_e, 64'h1004);
        w_regwrite_w = 0; w_regsrc_d = 0; w_inst_d = 32'h0081_0000; w_immsrc_d = 2'b10;
        tick;
        chk("w_r1_stored", w_rd1_e, 64'h1122_3344_5566_7788);
        chk("w_imm_br", w_extimm_e, 64'hFFFF_FFFF_FE04_0000);

        // Reset mid-stall discards held instruction and clears the file
        valid_d = 1; regwrite_d = 1; inst_d = 32'h0003_0000;
        tick;
        stall_e = 1;
        tick;
        #2 reset = 1'b0;
        #2;
        chk("rst_stall_valid", 64'(valid_e), 64'd0);
        chk("rst_stall_rd1", 64'(rd1_e), 64'd0);
        reset = 1'b1; stall_e = 0;
        tick;
        chk("rst_cleared_r3", 64'(rd1_e), 64'd0);
        chk("rst_reload_valid", 64'(valid_e), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Pipelined, parametrised successor to the single-cycle decode stage.
- Performs register-file read with write-through bypass, PC-relative R15 read, immediate extension and SrcB selection.
- Holds all results in an ID/EX pipeline register with valid, stall and flush control.
- Sits between the fetch pipeline register and the execute stage; writeback drives its write port.

Parameters:
- DW, 32, datapath width (must be ≥ 32; instruction stays 32 bits).
- NREGS, 16, architectural register count (power of 2, ≥ 16).
- AW, $clog2(NREGS), register address width (derived; do not override).
- PC_REG, NREGS-1, index of the register that reads as PC+8.
- PC_INC, 4, constant added to pcplus4_d to form the PC_REG read value.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_d  in  1  decode-stage instruction valid.
- inst_d  in  32  instruction in decode.
- pcplus4_d  in  DW  fetch PC+4 of inst_d.
- regsrc_d  in  2  [0]: RA1 = PC_REG; [1]: RA2 = inst[15:12], otherwise inst[3:0].
- immsrc_d  in  2  immediate format.
- alusrc_d  in  1  SrcB = ExtImm when 1, RD2 when 0.
- regwrite_d  in  1  control passed through to E.
- stall_e  in  1  hold the ID/EX register.
- flush_e  in  1  bubble the ID/EX register.
- regwrite_w  in  1  writeback enable.
- wa3_w  in  AW  writeback address.
- result_w  in  DW  writeback data.
- valid_e  out  1  E-stage valid.
- regwrite_e  out  1  registered regwrite, gated by valid.
- rd1_e, rd2_e, extimm_e, srcb_e, pcplus8_e  out  DW each  registered operands.
- ra1_e, ra2_e, wa3_e  out  AW each  registered addresses for a forwarding unit.

Behaviour:
- Register file:
  - NREGS x DW, written on the rising clk edge when regwrite_w=1 and wa3_w != PC_REG.
  - Writes to PC_REG are dropped.
  - Contents clear to 0 on reset.
- Read addresses (combinational in D):
  - ra1 = regsrc_d[0] ? PC_REG : inst_d[19:16]
  - ra2 = regsrc_d[1] ? inst_d[15:12] : inst_d[3:0]
  - wa3 = inst_d[15:12]
  - Address fields are zero-extended to AW.
- Read value priority, highest first:
  - ra == PC_REG → pcplus4_d + PC_INC.
  - regwrite_w and wa3_w == ra → result_w (same-cycle write-through bypass).
  - Otherwise the stored value.
- pcplus8 = pcplus4_d + PC_INC, modulo 2^DW; wrap-around is silent.
- ExtImm, sized to DW:
  - 00: zero-extend inst[7:0]
  - 01: zero-extend inst[11:0]
  - 10: sign-extend {inst[23:0], 2'b00}
  - 11: all zeros
- srcb = alusrc_d ? ExtImm : rd2. Computed in D, then registered.
- ID/EX register, evaluated on each rising clk edge:
  - flush_e=1 → valid_e=0 and regwrite_e=0; data fields hold their previous values. Flush beats stall.
  - else stall_e=1 → every E output holds.
  - else all fields load from D; valid_e=valid_d; regwrite_e = regwrite_d & valid_d.
- Latency: 1 cycle from D inputs to E outputs.
- Writeback is independent of stall and flush: the register-file write happens even while the ID/EX register is stalled.
- Reset (asynchronous assert, synchronous-safe deassert): every E output goes to 0 and every register-file entry goes to 0. Reset mid-stall discards the held instruction.
- Illegal ImmSrc (11) is not flagged; it produces 0.

Decomposition:
- Package decode_pkg:
  - imm_src_t enum (IMM_8, IMM_12, IMM_BR, IMM_RSV).
  - REGSRC_RA1_PC and REGSRC_RA2_RD bit-index constants.
  - Default PC_INC.
- Sub-module decode_regfile (params DW, NREGS, PC_REG):
  - Two read ports, one write port, write-through bypass, PC_REG override, asynchronous clear.
- Extender and muxes stay inline in decode_stage_pipe.

Test Plan:
- Reset, then read R1 and R2 → rd1_e=rd2_e=0, valid_e=0 while reset is low and one cycle after release.
- Write R3=0xDEADBEEF via W with inst_d reading R3 as RA1 in the same cycle → rd1_e=0xDEADBEEF next cycle (bypass).
- regsrc_d=01, pcplus4_d=0x100 → rd1_e=0x104 and pcplus8_e=0x104. Then write R15=0x55 → subsequent R15 read is still pcplus4_d+4.
- immsrc=10, inst[23:0]=0xFFFFFE → extimm_e=0xFFFFFFF8. immsrc=01, inst[11:0]=0xABC, alusrc=1 → srcb_e=0x00000ABC.
- stall_e for 3 cycles while D inputs change → E outputs frozen. Assert flush_e and stall_e together → valid_e=0 and regwrite_e=0.
- DW=64, NREGS=32: pcplus4_d=0xFFFF_FFFF_FFFF_FFFC → pcplus8_e=0 (wrap-around); write and read R31 against PC_REG=31 → override holds.
